// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - memory-op, FSM-state and access-size encodings for the MEM stage
// Contents: mem_op_e (ex_mem_op codes), mem_st_e (FSM states), DATA_SIZE_* codes,
//           decode helpers is_load / is_store / access_size / is_misaligned.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [2:0] {
    MEM_ST_IDLE  = 3'd0,
    MEM_ST_REQ   = 3'd1,
    MEM_ST_WAIT  = 3'd2,
    MEM_ST_DONE  = 3'd3,
    MEM_ST_DRAIN = 3'd4
  } mem_st_e;

  localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
  localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
  localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

  function automatic logic is_load(input mem_op_e op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: is_load = 1'b1;
      default:                                                 is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    case (op)
      MEM_OP_SB, MEM_OP_SH, MEM_OP_SW: is_store = 1'b1;
      default:                         is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] access_size(input mem_op_e op);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: access_size = DATA_SIZE_HALF;
      MEM_OP_LW, MEM_OP_SW:             access_size = DATA_SIZE_WORD;
      default:                          access_size = DATA_SIZE_BYTE;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      DATA_SIZE_HALF: is_misaligned = addr_lo[0];
      DATA_SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:        is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - sram-like data port between the MEM stage and the data memory
// Request side (master -> slave): data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
// Response side (slave -> master): data_addr_ok, data_data_ok, data_rdata
interface mem_access_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - picks the load lane from a read word and sign/zero-extends it
// Ports: op (load kind), addr_lo (address bits [1:0]), rdata (raw word), result (aligned value)
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: result = {24'd0, byte_sel};
      MEM_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: result = {16'd0, half_sel};
      MEM_OP_LW:  result = rdata;
      default:    result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: data-port FSM, store lanes, load alignment, address errors
// Ports: clk/rst (async active-high); exception (flush), exe_stall (downstream hold);
//        ex_mem_op/addr/store_data (access from EX); ex_* passthrough -> mem_* / in_wb_pc;
//        mem_adel/mem_ades/mem_badvaddr (address errors); data_stall (stall[3]);
//        data_if (master side of the sram-like data port).
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        exe_stall,

  input  mem_op_e     ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_store_data,

  input  logic        ex_regfile_write_enable,
  input  logic [4:0]  ex_regfile_write_addr,
  input  logic [31:0] ex_regfile_write_data,
  input  logic        ex_hi_write_enable,
  input  logic [31:0] ex_hi_write_data,
  input  logic        ex_lo_write_enable,
  input  logic [31:0] ex_lo_write_data,
  input  logic        ex_cp0_write_enable,
  input  logic [7:0]  ex_cp0_write_addr,
  input  logic [31:0] ex_cp0_write_data,
  input  logic [31:0] ex_pc,

  output logic        mem_regfile_write_enable,
  output logic [4:0]  mem_regfile_write_addr,
  output logic [31:0] mem_regfile_write_data,
  output logic        mem_hi_write_enable,
  output logic [31:0] mem_hi_write_data,
  output logic        mem_lo_write_enable,
  output logic [31:0] mem_lo_write_data,
  output logic        mem_cp0_write_enable,
  output logic [7:0]  mem_cp0_write_addr,
  output logic [31:0] mem_cp0_write_data,
  output logic [31:0] in_wb_pc,

  output logic        mem_adel,
  output logic        mem_ades,
  output logic [31:0] mem_badvaddr,
  output logic        data_stall,

  mem_access_if.master data_if
);

  mem_st_e     state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        op_load, op_store, misalign, access_valid;
  logic [1:0]  op_size;
  logic        req_c, stall_c;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] load_raw, load_result;

  // Access decode
  always_comb begin
    op_load      = is_load(ex_mem_op);
    op_store     = is_store(ex_mem_op);
    op_size      = access_size(ex_mem_op);
    misalign     = (op_load | op_store) & is_misaligned(op_size, ex_mem_addr[1:0]);
    access_valid = (op_load | op_store) & ~misalign;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_ST_IDLE;
      rdata_buf_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      MEM_ST_IDLE: begin
        if (access_valid && !exception)
          state_d = data_if.data_addr_ok ? MEM_ST_WAIT : MEM_ST_REQ;
      end
      MEM_ST_REQ: begin
        if (exception)                 state_d = MEM_ST_IDLE;
        else if (data_if.data_addr_ok) state_d = MEM_ST_WAIT;
      end
      MEM_ST_WAIT: begin
        if (exception) begin
          // An accepted request must still be answered; drain it unless it lands now.
          state_d = data_if.data_data_ok ? MEM_ST_IDLE : MEM_ST_DRAIN;
        end else if (data_if.data_data_ok) begin
          if (exe_stall) begin
            // Pipeline is held downstream: keep the read word so the result survives.
            rdata_buf_d = data_if.data_rdata;
            state_d     = MEM_ST_DONE;
          end else begin
            state_d = MEM_ST_IDLE;
          end
        end
      end
      MEM_ST_DONE: begin
        if (exception || !exe_stall) state_d = MEM_ST_IDLE;
      end
      MEM_ST_DRAIN: begin
        if (data_if.data_data_ok) state_d = MEM_ST_IDLE;
      end
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        req_c   = access_valid & ~exception;
        stall_c = access_valid & ~exception;
      end
      MEM_ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
      end
      MEM_ST_WAIT:  stall_c = ~data_if.data_data_ok;
      MEM_ST_DRAIN: stall_c = access_valid;
      default: begin
        req_c   = 1'b0;
        stall_c = 1'b0;
      end
    endcase
  end

  // Store lane placement
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'd0;
    case (op_size)
      DATA_SIZE_BYTE: begin
        st_wstrb = 4'b0001 << ex_mem_addr[1:0];
        st_wdata = {4{ex_mem_store_data[7:0]}};
      end
      DATA_SIZE_HALF: begin
        st_wstrb = 4'b0011 << {ex_mem_addr[1], 1'b0};
        st_wdata = {2{ex_mem_store_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = ex_mem_store_data;
      end
    endcase
  end

  // Request outputs are qualified by rst so a held access cannot re-issue while in reset.
  assign data_if.data_req   = req_c & ~rst;
  assign data_if.data_wr    = data_if.data_req & op_store;
  assign data_if.data_size  = data_if.data_req ? op_size : 2'd0;
  assign data_if.data_addr  = !data_if.data_req ? 32'd0 :
                              (op_size == DATA_SIZE_WORD) ? {ex_mem_addr[31:2], 2'b00} : ex_mem_addr;
  assign data_if.data_wstrb = data_if.data_wr ? st_wstrb : 4'b0000;
  assign data_if.data_wdata = data_if.data_wr ? st_wdata : 32'd0;
  assign data_stall         = stall_c & ~rst;

  // WAIT uses the live response; DONE replays the buffered word.
  assign load_raw = (state_q == MEM_ST_WAIT) ? data_if.data_rdata : rdata_buf_q;

  mem_access_load_align u_load_align (
    .op      (ex_mem_op),
    .addr_lo (ex_mem_addr[1:0]),
    .rdata   (load_raw),
    .result  (load_result)
  );

  assign mem_adel     = op_load & misalign;
  assign mem_ades     = op_store & misalign;
  assign mem_badvaddr = misalign ? ex_mem_addr : 32'd0;

  assign mem_regfile_write_enable = ex_regfile_write_enable & ~misalign;
  assign mem_regfile_write_addr   = ex_regfile_write_addr;
  assign mem_regfile_write_data   = op_load ? load_result : ex_regfile_write_data;
  assign mem_hi_write_enable      = ex_hi_write_enable;
  assign mem_hi_write_data        = ex_hi_write_data;
  assign mem_lo_write_enable      = ex_lo_write_enable;
  assign mem_lo_write_data        = ex_lo_write_data;
  assign mem_cp0_write_enable     = ex_cp0_write_enable;
  assign mem_cp0_write_addr       = ex_cp0_write_addr;
  assign mem_cp0_write_data       = ex_cp0_write_data;
  assign in_wb_pc                 = ex_pc;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst, exception, exe_stall;
  mem_op_e     ex_mem_op;
  logic [31:0] ex_mem_addr, ex_mem_store_data;
  logic        ex_regfile_write_enable, ex_hi_write_enable, ex_lo_write_enable, ex_cp0_write_enable;
  logic [4:0]  ex_regfile_write_addr;
  logic [7:0]  ex_cp0_write_addr;
  logic [31:0] ex_regfile_write_data, ex_hi_write_data, ex_lo_write_data, ex_cp0_write_data, ex_pc;
  logic        mem_regfile_write_enable, mem_hi_write_enable, mem_lo_write_enable, mem_cp0_write_enable;
  logic [4:0]  mem_regfile_write_addr;
  logic [7:0]  mem_cp0_write_addr;
  logic [31:0] mem_regfile_write_data, mem_hi_write_data, mem_lo_write_data, mem_cp0_write_data, in_wb_pc;
  logic        mem_adel, mem_ades, data_stall;
  logic [31:0] mem_badvaddr;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_if data_if();

  mem_access dut (
    .clk(clk), .rst(rst), .exception(exception), .exe_stall(exe_stall),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_store_data(ex_mem_store_data),
    .ex_regfile_write_enable(ex_regfile_write_enable), .ex_regfile_write_addr(ex_regfile_write_addr),
    .ex_regfile_write_data(ex_regfile_write_data),
    .ex_hi_write_enable(ex_hi_write_enable), .ex_hi_write_data(ex_hi_write_data),
    .ex_lo_write_enable(ex_lo_write_enable), .ex_lo_write_data(ex_lo_write_data),
    .ex_cp0_write_enable(ex_cp0_write_enable), .ex_cp0_write_addr(ex_cp0_write_addr),
    .ex_cp0_write_data(ex_cp0_write_data), .ex_pc(ex_pc),
    .mem_regfile_write_enable(mem_regfile_write_enable), .mem_regfile_write_addr(mem_regfile_write_addr),
    .mem_regfile_write_data(mem_regfile_write_data),
    .mem_hi_write_enable(mem_hi_write_enable), .mem_hi_write_data(mem_hi_write_data),
    .mem_lo_write_enable(mem_lo_write_enable), .mem_lo_write_data(mem_lo_write_data),
    .mem_cp0_write_enable(mem_cp0_write_enable), .mem_cp0_write_addr(mem_cp0_write_addr),
    .mem_cp0_write_data(mem_cp0_write_data), .in_wb_pc(in_wb_pc),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_badvaddr(mem_badvaddr),
    .data_stall(data_stall), .data_if(data_if)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exception = 0; exe_stall = 0;
    ex_mem_op = MEM_OP_NONE; ex_mem_addr = 0; ex_mem_store_data = 0;
    ex_regfile_write_enable = 0; ex_regfile_write_addr = 0; ex_regfile_write_data = 0;
    ex_hi_write_enable = 0; ex_hi_write_data = 0; ex_lo_write_enable = 0; ex_lo_write_data = 0;
    ex_cp0_write_enable = 0; ex_cp0_write_addr = 0; ex_cp0_write_data = 0; ex_pc = 0;
    data_if.data_addr_ok = 0; data_if.data_data_ok = 0; data_if.data_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); #2;
    n_cmp++; if (data_if.data_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0h want 0", data_if.data_req); end
    n_cmp++; if (data_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0h want 0", data_stall); end
    n_cmp++; if (mem_adel !== 1'b0 || mem_ades !== 1'b0) begin n_bad++; $display("FAIL reset_err: got adel=%0h ades=%0h want 0 0", mem_adel, mem_ades); end
    n_cmp++; if (mem_badvaddr !== 32'h0) begin n_bad++; $display("FAIL reset_badvaddr: got %h want 00000000", mem_badvaddr); end
    n_cmp++; if (mem_regfile_write_data !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 00000000", mem_regfile_write_data); end
    next_cycle(); next_cycle();
    rst = 0; #1;
  endtask

  task automatic test_passthrough();
    ex_regfile_write_enable = 1; ex_regfile_write_addr = 5'd17; ex_regfile_write_data = 32'hA5A5_0001;
    ex_hi_write_enable = 1; ex_hi_write_data = 32'h1111_2222; ex_lo_write_enable = 1; ex_lo_write_data = 32'h3333_4444;
    ex_cp0_write_enable = 1; ex_cp0_write_addr = 8'h62; ex_cp0_write_data = 32'h5555_6666; ex_pc = 32'hBFC0_0100;
    data_if.data_addr_ok = 1; #1;
    n_cmp++; if ({mem_regfile_write_enable, mem_regfile_write_addr, mem_regfile_write_data} !== {1'b1, 5'd17, 32'hA5A5_0001}) begin n_bad++; $display("FAIL pass_regfile: got %0h %0h %h want 1 11 a5a50001", mem_regfile_write_enable, mem_regfile_write_addr, mem_regfile_write_data); end
    n_cmp++; if ({mem_hi_write_enable, mem_hi_write_data, mem_lo_write_enable, mem_lo_write_data} !== {1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444}) begin n_bad++; $display("FAIL pass_hilo: got hi=%h lo=%h want 11112222 33334444", mem_hi_write_data, mem_lo_write_data); end
    n_cmp++; if ({mem_cp0_write_enable, mem_cp0_write_addr, mem_cp0_write_data, in_wb_pc} !== {1'b1, 8'h62, 32'h5555_6666, 32'hBFC0_0100}) begin n_bad++; $display("FAIL pass_cp0_pc: got %0h %h %h want 62 55556666 bfc00100", mem_cp0_write_addr, mem_cp0_write_data, in_wb_pc); end
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0) begin n_bad++; $display("FAIL pass_no_req: got req=%0h stall=%0h want 0 0", data_if.data_req, data_stall); end
    next_cycle(); clear_inputs(); #1;
  endtask

  task automatic test_lw();
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h1000; ex_regfile_write_enable = 1; ex_regfile_write_addr = 5'd5;
    data_if.data_addr_ok = 1; #1;
    n_cmp++; if (data_if.data_req !== 1'b1 || data_stall !== 1'b1) begin n_bad++; $display("FAIL lw_issue: got req=%0h stall=%0h want 1 1", data_if.data_req, data_stall); end
    n_cmp++; if ({data_if.data_wr, data_if.data_size, data_if.data_addr} !== {1'b0, 2'd2, 32'h1000}) begin n_bad++; $display("FAIL lw_cmd: got wr=%0h size=%0h addr=%h want 0 2 00001000", data_if.data_wr, data_if.data_size, data_if.data_addr); end
    next_cycle();
    data_if.data_addr_ok = 0; data_if.data_data_ok = 1; data_if.data_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0) begin n_bad++; $display("FAIL lw_resp: got req=%0h stall=%0h want 0 0", data_if.data_req, data_stall); end
    n_cmp++; if (mem_regfile_write_data !== 32'hDEAD_BEEF || mem_regfile_write_enable !== 1'b1) begin n_bad++; $display("FAIL lw_data: got %h we=%0h want deadbeef 1", mem_regfile_write_data, mem_regfile_write_enable); end
    next_cycle(); clear_inputs(); #1;
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0) begin n_bad++; $display("FAIL lw_idle: got req=%0h stall=%0h want 0 0", data_if.data_req, data_stall); end
  endtask

  task automatic test_load_align();
    mem_op_e     ops [6] = '{MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LB, MEM_OP_LH};
    logic [31:0] adr [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1000};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F, 32'hFFFF_FF7F};
    for (int i = 0; i < 6; i++) begin
      ex_mem_op = ops[i]; ex_mem_addr = adr[i]; ex_regfile_write_enable = 1; data_if.data_addr_ok = 1; #1;
      n_cmp++; if (data_if.data_req !== 1'b1 || data_if.data_addr !== adr[i]) begin n_bad++; $display("FAIL align_req[%0d]: got req=%0h addr=%h want 1 %h", i, data_if.data_req, data_if.data_addr, adr[i]); end
      next_cycle();
      data_if.data_addr_ok = 0; data_if.data_data_ok = 1; data_if.data_rdata = 32'h80FF_FF7F; #1;
      n_cmp++; if (mem_regfile_write_data !== exp[i]) begin n_bad++; $display("FAIL align_data[%0d]: got %h want %h", i, mem_regfile_write_data, exp[i]); end
      next_cycle(); clear_inputs(); #1;
    end
  endtask

  task automatic test_store();
    mem_op_e     ops  [5] = '{MEM_OP_SH, MEM_OP_SB, MEM_OP_SW, MEM_OP_SB, MEM_OP_SH};
    logic [31:0] adr  [5] = '{32'h2002, 32'h2001, 32'h2004, 32'h2003, 32'h2000};
    logic [31:0] sd   [5] = '{32'h1234_ABCD, 32'h0000_00A5, 32'h1122_3344, 32'hFFFF_FF3C, 32'h0000_9876};
    logic [3:0]  strb [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000, 4'b0011};
    logic [31:0] wd   [5] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'h1122_3344, 32'h3C3C_3C3C, 32'h9876_9876};
    logic [1:0]  sz   [5] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      ex_mem_op = ops[i]; ex_mem_addr = adr[i]; ex_mem_store_data = sd[i]; #1;
      n_cmp++; if ({data_if.data_req, data_if.data_wr, data_if.data_size} !== {1'b1, 1'b1, sz[i]}) begin n_bad++; $display("FAIL st_cmd[%0d]: got req=%0h wr=%0h size=%0h want 1 1 %0h", i, data_if.data_req, data_if.data_wr, data_if.data_size, sz[i]); end
      n_cmp++; if (data_if.data_wstrb !== strb[i] || data_if.data_wdata !== wd[i]) begin n_bad++; $display("FAIL st_lanes[%0d]: got strb=%b wdata=%h want %b %h", i, data_if.data_wstrb, data_if.data_wdata, strb[i], wd[i]); end
      next_cycle();
      data_if.data_addr_ok = 1; #1;
      n_cmp++; if (data_if.data_req !== 1'b1 || data_stall !== 1'b1 || data_if.data_addr !== adr[i]) begin n_bad++; $display("FAIL st_req_hold[%0d]: got req=%0h stall=%0h addr=%h want 1 1 %h", i, data_if.data_req, data_stall, data_if.data_addr, adr[i]); end
      next_cycle();
      data_if.data_addr_ok = 0; data_if.data_data_ok = 1; #1;
      n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0) begin n_bad++; $display("FAIL st_ack[%0d]: got req=%0h stall=%0h want 0 0", i, data_if.data_req, data_stall); end
      next_cycle(); clear_inputs(); #1;
    end
  endtask

  task automatic test_misalign();
    mem_op_e     ops [4] = '{MEM_OP_LW, MEM_OP_LH, MEM_OP_SW, MEM_OP_SH};
    logic [31:0] adr [4] = '{32'h1002, 32'h1001, 32'h2001, 32'h2003};
    logic        ld  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ex_mem_op = ops[i]; ex_mem_addr = adr[i]; ex_regfile_write_enable = 1; data_if.data_addr_ok = 1; #1;
      n_cmp++; if (mem_adel !== ld[i] || mem_ades !== !ld[i] || mem_badvaddr !== adr[i]) begin n_bad++; $display("FAIL mis_err[%0d]: got adel=%0h ades=%0h bad=%h want %0h %0h %h", i, mem_adel, mem_ades, mem_badvaddr, ld[i], !ld[i], adr[i]); end
      n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0 || mem_regfile_write_enable !== 1'b0) begin n_bad++; $display("FAIL mis_quiet[%0d]: got req=%0h stall=%0h we=%0h want 0 0 0", i, data_if.data_req, data_stall, mem_regfile_write_enable); end
      next_cycle();
      n_cmp++; if (data_if.data_req !== 1'b0) begin n_bad++; $display("FAIL mis_no_req[%0d]: got %0h want 0", i, data_if.data_req); end
      clear_inputs(); #1;
    end
  endtask

  task automatic test_done_hold();
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h3000; ex_regfile_write_enable = 1; exe_stall = 1; data_if.data_addr_ok = 1; #1;
    n_cmp++; if (data_if.data_req !== 1'b1) begin n_bad++; $display("FAIL done_issue: got %0h want 1", data_if.data_req); end
    next_cycle();
    data_if.data_addr_ok = 0; data_if.data_data_ok = 1; data_if.data_rdata = 32'hCAFE_F00D; #1;
    n_cmp++; if (mem_regfile_write_data !== 32'hCAFE_F00D || data_stall !== 1'b0) begin n_bad++; $display("FAIL done_first: got %h stall=%0h want cafef00d 0", mem_regfile_write_data, data_stall); end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      data_if.data_data_ok = 0; data_if.data_rdata = 32'h1234_5678; #1;
      n_cmp++; if (mem_regfile_write_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL done_buf[%0d]: got %h want cafef00d", c, mem_regfile_write_data); end
      n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0) begin n_bad++; $display("FAIL done_quiet[%0d]: got req=%0h stall=%0h want 0 0", c, data_if.data_req, data_stall); end
    end
    exe_stall = 0; #1;
    n_cmp++; if (mem_regfile_write_data !== 32'hCAFE_F00D || data_if.data_req !== 1'b0) begin n_bad++; $display("FAIL done_release: got %h req=%0h want cafef00d 0", mem_regfile_write_data, data_if.data_req); end
    next_cycle(); clear_inputs(); #1;
  endtask

  task automatic test_exception_in_req();
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h7000; #1;
    next_cycle();
    exception = 1; #1;
    next_cycle();
    exception = 0; ex_mem_op = MEM_OP_SW; ex_mem_addr = 32'h7004; ex_mem_store_data = 32'h0BAD_CAFE; #1;
    n_cmp++; if (data_if.data_req !== 1'b1 || data_if.data_wr !== 1'b1) begin n_bad++; $display("FAIL exreq_idle: got req=%0h wr=%0h want 1 1", data_if.data_req, data_if.data_wr); end
    data_if.data_addr_ok = 1;
    next_cycle();
    data_if.data_addr_ok = 0; data_if.data_data_ok = 1; #1;
    next_cycle(); clear_inputs(); #1;
  endtask

  task automatic test_drain();
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h4000; ex_regfile_write_enable = 1; data_if.data_addr_ok = 1; #1;
    next_cycle();
    data_if.data_addr_ok = 0; exception = 1; #1;
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b1) begin n_bad++; $display("FAIL drain_wait: got req=%0h stall=%0h want 0 1", data_if.data_req, data_stall); end
    next_cycle();
    exception = 0; ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h5000; #1;
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b1) begin n_bad++; $display("FAIL drain_hold: got req=%0h stall=%0h want 0 1", data_if.data_req, data_stall); end
    next_cycle();
    data_if.data_data_ok = 1; data_if.data_rdata = 32'hBAD0_BAD0; #1;
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b1) begin n_bad++; $display("FAIL drain_ack: got req=%0h stall=%0h want 0 1", data_if.data_req, data_stall); end
    next_cycle();
    data_if.data_data_ok = 0; #1;
    n_cmp++; if (data_if.data_req !== 1'b1 || data_if.data_addr !== 32'h5000) begin n_bad++; $display("FAIL drain_next_req: got req=%0h addr=%h want 1 00005000", data_if.data_req, data_if.data_addr); end
    data_if.data_addr_ok = 1;
    next_cycle();
    data_if.data_addr_ok = 0; data_if.data_data_ok = 1; data_if.data_rdata = 32'h600D_F00D; #1;
    n_cmp++; if (mem_regfile_write_data !== 32'h600D_F00D) begin n_bad++; $display("FAIL drain_next_data: got %h want 600df00d", mem_regfile_write_data); end
    next_cycle(); clear_inputs(); #1;
  endtask

  task automatic test_rst_in_wait();
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h6000; data_if.data_addr_ok = 1; #1;
    next_cycle();
    data_if.data_addr_ok = 0; #1;
    n_cmp++; if (data_stall !== 1'b1) begin n_bad++; $display("FAIL rstw_wait: got stall=%0h want 1", data_stall); end
    rst = 1; #1;
    n_cmp++; if (data_if.data_req !== 1'b0 || data_stall !== 1'b0) begin n_bad++; $display("FAIL rstw_async: got req=%0h stall=%0h want 0 0", data_if.data_req, data_stall); end
    next_cycle();
    rst = 0; #1;
    n_cmp++; if (data_if.data_req !== 1'b1 || data_stall !== 1'b1) begin n_bad++; $display("FAIL rstw_reissue: got req=%0h stall=%0h want 1 1", data_if.data_req, data_stall); end
    data_if.data_addr_ok = 1;
    next_cycle();
    data_if.data_addr_ok = 0; data_if.data_data_ok = 1; data_if.data_rdata = 32'h0123_4567; #1;
    n_cmp++; if (mem_regfile_write_data !== 32'h0123_4567) begin n_bad++; $display("FAIL rstw_data: got %h want 01234567", mem_regfile_write_data); end
    next_cycle(); clear_inputs(); #1;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_load_align();
    test_store();
    test_misalign();
    test_done_hold();
    test_exception_in_req();
    test_drain();
    test_rst_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
